// File: rtl/tone_arbiter.sv
// Fixed-priority arbiter sharing one buzzer tone word between three sources, with hold-before-preempt.
// Define TONE_ARB_GAP_EN to insert a GAP_CYCLES silence gap between successive owners.
module tone_arbiter #(
    parameter int unsigned GAP_CYCLES = 100000,
    parameter int unsigned MIN_HOLD   = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [31:0] freq0,
    input  logic [31:0] freq1,
    input  logic [31:0] freq2,
    input  logic        flush,
    output logic [2:0]  gnt,
    output logic [31:0] frequency,
    output logic [1:0]  owner,
    output logic        busy,
    output logic        preempted
);

    localparam logic [1:0] OWNER_NONE = 2'd3;

    if (GAP_CYCLES == 0) begin : g_gap_cfg
        $error("tone_arbiter: GAP_CYCLES must be >= 1");
    end

`ifdef TONE_ARB_GAP_EN
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;
    localparam state_t S_LEAVE = S_GAP;
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
    logic [31:0] r_gap_cnt;
    logic [31:0] w_gap_nxt;
`else
    typedef enum logic [0:0] {S_IDLE, S_GRANT} state_t;
    localparam state_t S_LEAVE = S_IDLE;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_gnt;
    logic [31:0] r_freq;
    logic [1:0]  r_owner;
    logic        r_pre;
    logic [31:0] r_hold_cnt;

    logic [1:0]  w_win_idx;
    logic [31:0] w_win_freq;
    logic        w_own_req;
    logic        w_higher;
    logic [31:0] w_own_freq;
    logic        w_hold_done;
    logic        w_release;
    logic        w_preempt;
    logic [2:0]  w_gnt_nxt;
    logic [31:0] w_freq_nxt;
    logic [1:0]  w_owner_nxt;
    logic        w_pre_nxt;
    logic [31:0] w_hold_nxt;

    // Lowest set index wins.
    always_comb begin
        w_win_idx  = OWNER_NONE;
        w_win_freq = '0;
        if (req[0]) begin
            w_win_idx  = 2'd0;
            w_win_freq = freq0;
        end else if (req[1]) begin
            w_win_idx  = 2'd1;
            w_win_freq = freq1;
        end else if (req[2]) begin
            w_win_idx  = 2'd2;
            w_win_freq = freq2;
        end
    end

    always_comb begin
        w_own_req  = 1'b0;
        w_own_freq = '0;
        w_higher   = 1'b0;
        case (r_owner)
            2'd0: begin
                w_own_req  = req[0];
                w_own_freq = freq0;
            end
            2'd1: begin
                w_own_req  = req[1];
                w_own_freq = freq1;
                w_higher   = req[0];
            end
            2'd2: begin
                w_own_req  = req[2];
                w_own_freq = freq2;
                w_higher   = |req[1:0];
            end
            default: ;
        endcase
    end

    assign w_hold_done = (r_hold_cnt >= 32'(MIN_HOLD));
    assign w_release   = !w_own_req;
    // Release takes precedence, so a preempt only counts while the owner still requests.
    assign w_preempt   = w_own_req && w_higher && w_hold_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_win_idx != OWNER_NONE) w_state_nxt = S_GRANT;
                S_GRANT: if (w_release || w_preempt) w_state_nxt = S_LEAVE;
`ifdef TONE_ARB_GAP_EN
                S_GAP:   if (r_gap_cnt == GAP_LAST) w_state_nxt = S_IDLE;
`endif
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_gnt_nxt   = '0;
        w_freq_nxt  = '0;
        w_owner_nxt = OWNER_NONE;
        w_pre_nxt   = 1'b0;
        w_hold_nxt  = '0;
`ifdef TONE_ARB_GAP_EN
        w_gap_nxt   = '0;
`endif
        if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_idx != OWNER_NONE) begin
                        w_gnt_nxt   = 3'b001 << w_win_idx;
                        w_owner_nxt = w_win_idx;
                        w_freq_nxt  = w_win_freq;
                    end
                end
                S_GRANT: begin
                    if (!w_release && !w_preempt) begin
                        w_gnt_nxt   = r_gnt;
                        w_owner_nxt = r_owner;
                        w_freq_nxt  = w_own_freq;
                        w_hold_nxt  = w_hold_done ? r_hold_cnt : r_hold_cnt + 32'd1;
                    end else begin
                        w_pre_nxt = w_preempt;
                    end
                end
`ifdef TONE_ARB_GAP_EN
                S_GAP: w_gap_nxt = r_gap_cnt + 32'd1;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt      <= '0;
            r_freq     <= '0;
            r_owner    <= OWNER_NONE;
            r_pre      <= 1'b0;
            r_hold_cnt <= '0;
`ifdef TONE_ARB_GAP_EN
            r_gap_cnt  <= '0;
`endif
        end else begin
            r_gnt      <= w_gnt_nxt;
            r_freq     <= w_freq_nxt;
            r_owner    <= w_owner_nxt;
            r_pre      <= w_pre_nxt;
            r_hold_cnt <= w_hold_nxt;
`ifdef TONE_ARB_GAP_EN
            r_gap_cnt  <= w_gap_nxt;
`endif
        end
    end

    assign gnt       = r_gnt;
    assign frequency = r_freq;
    assign owner     = r_owner;
    assign busy      = (r_state != S_IDLE);
    assign preempted = r_pre;

endmodule
